result_streamer: RTL and testbench

//  Drains a run of BUFFER_WORD_SIZE-bit words from the unified buffer into the TX FIFO as bytes.
//  It is the outbound counterpart of the RX instruction/data fetch path: the controller starts it
//  in STORE_STREAM with a base address and a word count. It waits until every byte has been

---
 rtl/utpu_pkg.sv | 19 +
 rtl/result_streamer.sv | 125 ++++++++++++
 tb/tb_result_streamer.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/utpu_pkg.sv
// Shared types and width constants for the unified-buffer datapath blocks.
package utpu_pkg;

  // Width of one TX/RX FIFO entry.
  localparam int FIFO_DATA_WIDTH  = 8;
  // Width of one unified-buffer word: two FIFO bytes.
  localparam int BUFFER_WORD_SIZE = 16;

  // Result streamer sequencing states.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_READ    = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_SEND_LO = 3'd3,
    ST_SEND_HI = 3'd4,
    ST_DONE    = 3'd5
  } streamer_state_e;

endpackage

// File: rtl/result_streamer.sv
// Result streamer: reads a run of words from the unified buffer and pushes
// each one to the TX FIFO as two bytes, low byte first, honouring FIFO full.
module result_streamer #(
  parameter int BUFFER_SIZE      = 1024,
  parameter int BUFFER_WORD_SIZE = utpu_pkg::BUFFER_WORD_SIZE,
  parameter int FIFO_DATA_WIDTH  = utpu_pkg::FIFO_DATA_WIDTH,
  parameter int ADDRESS_SIZE     = $clog2(BUFFER_SIZE),
  parameter int COUNT_WIDTH      = ADDRESS_SIZE + 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [ADDRESS_SIZE-1:0]     base_addr,
  input  logic [COUNT_WIDTH-1:0]      word_count,
  output logic                        busy,
  output logic                        done,
  output logic                        buf_re,
  output logic [ADDRESS_SIZE-1:0]     buf_addr,
  input  logic [BUFFER_WORD_SIZE-1:0] buf_rdata,
  output logic                        fifo_we,
  output logic [FIFO_DATA_WIDTH-1:0]  fifo_wdata,
  input  logic                        fifo_full
);

  import utpu_pkg::*;

  // A buffer word must split into exactly two FIFO bytes.
  if (BUFFER_WORD_SIZE != 2 * FIFO_DATA_WIDTH) begin : g_width_check
    $error("result_streamer: BUFFER_WORD_SIZE must equal 2*FIFO_DATA_WIDTH");
  end

  localparam logic [ADDRESS_SIZE-1:0] LAST_ADDR = ADDRESS_SIZE'(BUFFER_SIZE - 1);

  streamer_state_e                state_r;
  streamer_state_e                state_nxt_s;
  logic [ADDRESS_SIZE-1:0]        addr_r;
  logic [COUNT_WIDTH-1:0]         remaining_r;
  logic [BUFFER_WORD_SIZE-1:0]    word_r;
  logic                           last_word_s;

  // The word being sent is the final one of the run.
  assign last_word_s = (remaining_r == COUNT_WIDTH'(1));

  // Next-state logic; byte states only advance when the FIFO accepts the byte.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          if (word_count == '0) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_READ;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_READ:    state_nxt_s = ST_CAPTURE;
      ST_CAPTURE: state_nxt_s = ST_SEND_LO;
      ST_SEND_LO: begin
        if (!fifo_full) begin
          state_nxt_s = ST_SEND_HI;
        end else begin
          state_nxt_s = ST_SEND_LO;
        end
      end
      ST_SEND_HI: begin
        if (!fifo_full) begin
          state_nxt_s = last_word_s ? ST_DONE : ST_READ;
        end else begin
          state_nxt_s = ST_SEND_HI;
        end
      end
      ST_DONE:    state_nxt_s = ST_IDLE;
      default:    state_nxt_s = ST_IDLE;
    endcase
  end

  // State, transfer bookkeeping and captured word; reset aborts any run.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      addr_r      <= '0;
      remaining_r <= '0;
      word_r      <= '0;
    end else begin
      state_r <= state_nxt_s;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            addr_r      <= base_addr;
            remaining_r <= word_count;
          end
        end
        ST_CAPTURE: begin
          word_r <= buf_rdata;
        end
        ST_SEND_HI: begin
          if (!fifo_full) begin
            addr_r      <= (addr_r == LAST_ADDR) ? '0 : addr_r + ADDRESS_SIZE'(1);
            remaining_r <= remaining_r - COUNT_WIDTH'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Output decode straight from the state register; byte select is a 2:1 mux.
  always_comb begin
    busy       = (state_r != ST_IDLE);
    done       = (state_r == ST_DONE);
    buf_re     = (state_r == ST_READ);
    buf_addr   = addr_r;
    fifo_we    = ((state_r == ST_SEND_LO) || (state_r == ST_SEND_HI)) && !fifo_full;
    if (state_r == ST_SEND_HI) begin
      fifo_wdata = word_r[BUFFER_WORD_SIZE-1:FIFO_DATA_WIDTH];
    end else begin
      fifo_wdata = word_r[FIFO_DATA_WIDTH-1:0];
    end
  end

endmodule

// File: tb/tb_result_streamer.sv
// Directed bench for result_streamer: buffer model with 1-cycle read latency,
// byte/address monitors, hand-computed expectations.
module tb_result_streamer;

  logic        clk;
  logic        rst;
  logic        start;
  logic [9:0]  base_addr;
  logic [10:0] word_count;
  logic        busy;
  logic        done;
  logic        buf_re;
  logic [9:0]  buf_addr;
  logic [15:0] buf_rdata;
  logic        fifo_we;
  logic [7:0]  fifo_wdata;
  logic        fifo_full;

  result_streamer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .busy       (busy),
    .done       (done),
    .buf_re     (buf_re),
    .buf_addr   (buf_addr),
    .buf_rdata  (buf_rdata),
    .fifo_we    (fifo_we),
    .fifo_wdata (fifo_wdata),
    .fifo_full  (fifo_full)
  );

  logic [15:0] mem [0:1023];
  logic [7:0]  wr_q[$];
  logic [9:0]  rd_q[$];
  int          cyc;
  int          done_cnt;
  int          done_cyc;
  int          first_we_cyc;
  bit          rand_full_en;
  int          n_checks;
  int          n_pass;

  // Clock: 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter; value during a cycle is the number of rising edges so far.
  always @(posedge clk) cyc++;

  // Buffer model with one-cycle read latency.
  always @(posedge clk) begin
    if (buf_re) buf_rdata <= mem[buf_addr];
  end

  // Random backpressure driver, active only when enabled.
  always begin
    @(posedge clk);
    #1;
    if (rand_full_en) fifo_full = 1'($urandom_range(0, 1));
  end

  // Monitors, sampled on the falling edge.
  always @(negedge clk) begin
    if (fifo_we) begin
      wr_q.push_back(fifo_wdata);
      if (first_we_cyc < 0) first_we_cyc = cyc;
    end
    if (buf_re) rd_q.push_back(buf_addr);
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    wr_q.delete();
    rd_q.delete();
    first_we_cyc = -1;
  endtask

  // Drive a one-cycle start; returns the index of the start cycle.
  task automatic do_start(input logic [9:0] b, input logic [10:0] n, output int s);
    @(posedge clk);
    #1;
    start      = 1'b1;
    base_addr  = b;
    word_count = n;
    s          = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Wait (bounded) for one more done pulse than base_cnt.
  task automatic wait_done(input int base_cnt, input int budget, input string tag);
    for (int i = 0; i < budget && done_cnt == base_cnt; i++) @(posedge clk);
    check_eq(tag, 32'(done_cnt), 32'(base_cnt + 1));
  endtask

  function automatic logic [31:0] pack4();
    logic [31:0] v;
    v = 32'hFFFF_FFFF;
    if (wr_q.size() == 4) v = {wr_q[0], wr_q[1], wr_q[2], wr_q[3]};
    return v;
  endfunction

  initial begin
    int s;
    int d0;
    int errs;
    int counts [3];
    n_checks = 0;
    n_pass = 0;
    cyc = 0;
    done_cnt = 0;
    done_cyc = -1;
    first_we_cyc = -1;
    rand_full_en = 1'b0;
    rst = 1'b0;
    start = 1'b0;
    base_addr = 10'd0;
    word_count = 11'd0;
    fifo_full = 1'b0;
    buf_rdata = 16'd0;
    for (int i = 0; i < 1024; i++) mem[i] = 16'(i * 7 + 3);

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset_outputs", {26'd0, busy, done, buf_re, fifo_we, |buf_addr, |fifo_wdata}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // 1: two words, no backpressure.
    mem[5] = 16'hA1B2;
    mem[6] = 16'hC3D4;
    clear_mon();
    d0 = done_cnt;
    do_start(10'd5, 11'd2, s);
    wait_done(d0, 40, "t1_done");
    @(negedge clk);
    check_eq("t1_busy_after_done", 32'(busy), 32'd0);
    check_eq("t1_bytes", pack4(), 32'hB2A1D4C3);
    check_eq("t1_reads", {11'd0, 11'(rd_q.size()), (rd_q.size() == 2) ? rd_q[0] : 10'h3FF}, {11'd0, 11'd2, 10'd5});
    check_eq("t1_first_we_lat", 32'(first_we_cyc - s), 32'd3);
    check_eq("t1_done_lat", 32'(done_cyc - s), 32'd9);
    repeat (5) @(posedge clk);
    check_eq("t1_done_once", 32'(done_cnt), 32'(d0 + 1));

    // 2: zero-length run goes IDLE -> DONE -> IDLE.
    clear_mon();
    d0 = done_cnt;
    do_start(10'd5, 11'd0, s);
    wait_done(d0, 20, "t2_done");
    check_eq("t2_done_lat", 32'(done_cyc - s), 32'd1);
    check_eq("t2_no_traffic", 32'(wr_q.size() + rd_q.size()), 32'd0);

    // 3: FIFO full for 5 cycles while the high byte of word 0 is pending.
    clear_mon();
    d0 = done_cnt;
    do_start(10'd5, 11'd2, s);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    fifo_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("t3_hold", {23'd0, fifo_we, fifo_wdata}, {23'd0, 1'b0, 8'hA1});
      @(posedge clk);
    end
    #1;
    fifo_full = 1'b0;
    wait_done(d0, 40, "t3_done");
    check_eq("t3_bytes", pack4(), 32'hB2A1D4C3);
    check_eq("t3_done_lat", 32'(done_cyc - s), 32'd14);

    // 5: second start ignored while busy; reset aborts the run.
    for (int i = 10; i < 14; i++) mem[i] = 16'(16'h5500 + i);
    clear_mon();
    d0 = done_cnt;
    do_start(10'd10, 11'd4, s);
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = 1'b1;
    base_addr = 10'd0;
    word_count = 11'd1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check_eq("t5_reset_outputs", {26'd0, busy, done, buf_re, fifo_we, |buf_addr, |fifo_wdata}, 32'd0);
    check_eq("t5_reads_before_reset",
             {11'(rd_q.size()), (rd_q.size() == 2) ? {rd_q[0], rd_q[1]} : 20'hFFFFF},
             {11'd2, 10'd10, 10'd11});
    clear_mon();
    repeat (20) @(posedge clk);
    check_eq("t5_idle_after_reset", 32'(wr_q.size() + rd_q.size() + (done_cnt - d0)), 32'd0);

    // 4: address wrap from the last buffer word to word 0.
    mem[1023] = 16'h1122;
    mem[0]    = 16'h3344;
    clear_mon();
    d0 = done_cnt;
    do_start(10'd1023, 11'd2, s);
    wait_done(d0, 40, "t4_done");
    check_eq("t4_bytes", pack4(), 32'h22114433);
    check_eq("t4_addrs",
             {11'(rd_q.size()), (rd_q.size() == 2) ? {rd_q[0], rd_q[1]} : 20'hFFFFF},
             {11'd2, 10'd1023, 10'd0});

    // 6: random words under random backpressure, lengths 1..1024.
    counts[0] = 1;
    counts[1] = 37;
    counts[2] = 1024;
    rand_full_en = 1'b1;
    foreach (counts[k]) begin
      logic [9:0] b;
      for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
      b = 10'($urandom_range(0, 1023));
      clear_mon();
      d0 = done_cnt;
      do_start(b, 11'(counts[k]), s);
      wait_done(d0, counts[k] * 40 + 40, "t6_done");
      check_eq("t6_byte_count", 32'(wr_q.size()), 32'(2 * counts[k]));
      errs = 0;
      for (int w = 0; w < counts[k]; w++) begin
        logic [15:0] exp_w;
        exp_w = mem[10'(int'(b) + w)];
        if (2 * w + 1 < wr_q.size()) begin
          if (wr_q[2 * w] !== exp_w[7:0] || wr_q[2 * w + 1] !== exp_w[15:8]) errs++;
        end else begin
          errs++;
        end
      end
      check_eq("t6_byte_order", 32'(errs), 32'd0);
    end
    rand_full_en = 1'b0;
    @(posedge clk); #1;
    fifo_full = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
